// File: rtl/dp_ctrl_pkg.sv
// dp_ctrl_pkg: shared types and constants for the datapath controller.
//   state_t     controller FSM states
//   OPC_* / OP_* instruction opcode and op-field values
//   *_MSB/*_LSB instruction field bit positions
//   dec_t       decoded view of one instruction word
package dp_ctrl_pkg;

    typedef enum logic [2:0] {
        WAIT,
        DECODE,
        WRITE_IMM,
        LOAD_AB,
        EXEC,
        WB
    } state_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_MOVR = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MVN  = 2'b11;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 13;
    localparam int OP_MSB  = 12;
    localparam int OP_LSB  = 11;
    localparam int RN_MSB  = 10;
    localparam int RN_LSB  = 8;
    localparam int RD_MSB  = 7;
    localparam int RD_LSB  = 5;
    localparam int SH_MSB  = 4;
    localparam int SH_LSB  = 3;
    localparam int RM_MSB  = 2;
    localparam int RM_LSB  = 0;
    localparam int IMM_MSB = 7;

    typedef struct packed {
        logic [2:0] rn;
        logic [2:0] rd;
        logic [2:0] rm;
        logic [1:0] op;
        logic [1:0] sh;
        logic       is_movi;
        logic       is_movr;
        logic       is_alu;
        logic       is_cmp;
        logic       is_mvn;
        logic       legal;
    } dec_t;

endpackage

// File: rtl/datapath_ctrl_instr_dec.sv
// instr_dec: combinational instruction decoder.
//   ir      in   16     instruction word to decode
//   dec     out  dec_t  register fields, op class flags, legality
//   sximm8  out  WIDTH  imm8 sign-extended to the datapath width
module instr_dec
    import dp_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [15:0]      ir,
    output dec_t             dec,
    output logic [WIDTH-1:0] sximm8
);

    logic [2:0] opc;
    logic [1:0] op;

    assign opc = ir[OPC_MSB:OPC_LSB];
    assign op  = ir[OP_MSB:OP_LSB];

    always_comb begin
        dec         = '0;
        dec.rn      = ir[RN_MSB:RN_LSB];
        dec.rd      = ir[RD_MSB:RD_LSB];
        dec.rm      = ir[RM_MSB:RM_LSB];
        dec.op      = op;
        dec.sh      = ir[SH_MSB:SH_LSB];
        dec.is_movi = (opc == OPC_MOV) && (op == OP_MOVI);
        dec.is_movr = (opc == OPC_MOV) && (op == OP_MOVR);
        // every op value under the ALU opcode is a legal instruction
        dec.is_alu  = (opc == OPC_ALU);
        dec.is_cmp  = (opc == OPC_ALU) && (op == OP_CMP);
        dec.is_mvn  = (opc == OPC_ALU) && (op == OP_MVN);
        dec.legal   = dec.is_movi || dec.is_movr || dec.is_alu;
    end

    assign sximm8 = {{(WIDTH-8){ir[IMM_MSB]}}, ir[IMM_MSB:0]};

endmodule

// File: rtl/datapath_ctrl.sv
// datapath_ctrl: multi-cycle controller sequencing the register/ALU datapath.
// Latches an instruction on s while idle, decodes it and drives the datapath
// control inputs, one state per cycle. All outputs are registered.
//   clk, reset             clock, synchronous active-high reset
//   s, instr               start strobe and instruction (taken only in WAIT)
//   w, err                 idle/ready flag, illegal-instruction pulse
//   sximm8                 sign-extended imm8 of the latched instruction
//   vsel/writenum/write    register file write side
//   readnum1/readnum2      register file read addresses
//   loada/loadb/loadc/loads  datapath register load enables
//   asel/bsel/shift/aluop  ALU operand selects and operation
// Build option: DATAPATH_CTRL_FLAGS_ALL_EN makes every ALU-class instruction
// (ADD, CMP, AND, MVN) update the Z flag instead of CMP alone.
//
// state     | meaning
// ----------+---------------------------------------------------
// WAIT      | idle, w=1, accepts an instruction on s
// DECODE    | classify latched instruction, err pulse if illegal
// WRITE_IMM | write sximm8 into Rn
// LOAD_AB   | read Rn into A and Rm into B
// EXEC      | shift B, run ALU into C (and Z where applicable)
// WB        | write C into Rd
module datapath_ctrl
    import dp_ctrl_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s,
    input  logic [15:0]           instr,
    output logic                  w,
    output logic                  err,
    output logic [WIDTH-1:0]      sximm8,
    output logic                  vsel,
    output logic [ADDR_WIDTH-1:0] writenum,
    output logic                  write,
    output logic [ADDR_WIDTH-1:0] readnum1,
    output logic [ADDR_WIDTH-1:0] readnum2,
    output logic                  loada,
    output logic                  loadb,
    output logic                  asel,
    output logic                  bsel,
    output logic [1:0]            shift,
    output logic [1:0]            aluop,
    output logic                  loadc,
    output logic                  loads
);

    state_t           state;
    state_t           state_next;
    logic [15:0]      ir;
    logic [15:0]      ir_d;
    dec_t             dec;
    logic [WIDTH-1:0] sximm8_d;
    logic             loads_en;

    // Decode the value the instruction register is about to hold, so the
    // registered outputs of each state match the instruction in flight.
    assign ir_d = (state == WAIT && s) ? instr : ir;

    instr_dec #(.WIDTH(WIDTH)) u_dec (
        .ir     (ir_d),
        .dec    (dec),
        .sximm8 (sximm8_d)
    );

`ifdef DATAPATH_CTRL_FLAGS_ALL_EN
    assign loads_en = dec.is_alu;
`else
    assign loads_en = dec.is_cmp;
`endif

    always_comb begin
        state_next = state;
        case (state)
            WAIT:      state_next = s ? DECODE : WAIT;
            DECODE:    state_next = !dec.legal ? WAIT :
                                    (dec.is_movi ? WRITE_IMM : LOAD_AB);
            WRITE_IMM: state_next = WAIT;
            LOAD_AB:   state_next = EXEC;
            EXEC:      state_next = dec.is_cmp ? WAIT : WB;
            WB:        state_next = WAIT;
            default:   state_next = WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= WAIT;
            ir       <= '0;
            sximm8   <= '0;
            w        <= 1'b1;
            err      <= 1'b0;
            vsel     <= 1'b0;
            writenum <= '0;
            write    <= 1'b0;
            readnum1 <= '0;
            readnum2 <= '0;
            loada    <= 1'b0;
            loadb    <= 1'b0;
            asel     <= 1'b0;
            bsel     <= 1'b0;
            shift    <= '0;
            aluop    <= '0;
            loadc    <= 1'b0;
            loads    <= 1'b0;
        end else begin
            state    <= state_next;
            ir       <= ir_d;
            sximm8   <= sximm8_d;
            w        <= (state_next == WAIT);
            err      <= 1'b0;
            vsel     <= 1'b0;
            writenum <= '0;
            write    <= 1'b0;
            readnum1 <= '0;
            readnum2 <= '0;
            loada    <= 1'b0;
            loadb    <= 1'b0;
            asel     <= 1'b0;
            bsel     <= 1'b0;
            shift    <= '0;
            aluop    <= '0;
            loadc    <= 1'b0;
            loads    <= 1'b0;
            case (state_next)
                DECODE: err <= !dec.legal;
                WRITE_IMM: begin
                    vsel     <= 1'b1;
                    write    <= 1'b1;
                    writenum <= dec.rn;
                end
                LOAD_AB: begin
                    readnum1 <= dec.rn;
                    readnum2 <= dec.rm;
                    loada    <= 1'b1;
                    loadb    <= 1'b1;
                end
                EXEC: begin
                    shift <= dec.sh;
                    bsel  <= 1'b1;
                    loadc <= 1'b1;
                    // ALU op codes coincide with the op field; MOV reg passes B
                    aluop <= dec.is_movr ? 2'b00 : dec.op;
                    asel  <= dec.is_alu && !dec.is_mvn;
                    loads <= loads_en;
                end
                WB: begin
                    write    <= 1'b1;
                    writenum <= dec.rd;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_ctrl.sv
module tb_datapath_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        w, err, vsel, write, loada, loadb, asel, bsel, loadc, loads;
    logic [15:0] sximm8;
    logic [2:0]  writenum, readnum1, readnum2;
    logic [1:0]  shift, aluop;

    int checks = 0;
    int errors = 0;

`ifdef DATAPATH_CTRL_FLAGS_ALL_EN
    localparam bit FLAGS_ALL = 1'b1;
`else
    localparam bit FLAGS_ALL = 1'b0;
`endif

    datapath_ctrl #(.WIDTH(16), .ADDR_WIDTH(3)) dut (
        .clk(clk), .reset(reset), .s(s), .instr(instr),
        .w(w), .err(err), .sximm8(sximm8), .vsel(vsel),
        .writenum(writenum), .write(write),
        .readnum1(readnum1), .readnum2(readnum2),
        .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel),
        .shift(shift), .aluop(aluop), .loadc(loadc), .loads(loads)
    );

    always #5 clk = ~clk;

    // ---------------- datapath plant driven by the controller ----------------
    logic [15:0] rf [8];
    logic [15:0] ra = 16'h0, rb = 16'h0, rc = 16'h0;
    logic        zf = 1'b0;

    initial for (int i = 0; i < 8; i++) rf[i] = 16'h0;

    function automatic logic [15:0] shifter(input logic [15:0] b, input logic [1:0] sh);
        case (sh)
            2'b01:   return {b[14:0], 1'b0};
            2'b10:   return {1'b0, b[15:1]};
            2'b11:   return {b[15], b[15:1]};
            default: return b;
        endcase
    endfunction

    function automatic logic [15:0] alu(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return ~b;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [15:0] res;
        res = alu(asel ? ra : 16'h0, bsel ? shifter(rb, shift) : 16'h0, aluop);
        if (write) rf[writenum] <= vsel ? sximm8 : rc;
        if (loada) ra <= rf[readnum1];
        if (loadb) rb <= rf[readnum2];
        if (loadc) rc <= res;
        if (loads) zf <= (res == 16'h0);
    end

    // ---------------- behavioural controller model ----------------
    typedef struct packed {
        logic        w;
        logic        err;
        logic [15:0] sximm8;
        logic        vsel;
        logic [2:0]  writenum;
        logic        write;
        logic [2:0]  readnum1;
        logic [2:0]  readnum2;
        logic        loada;
        logic        loadb;
        logic        asel;
        logic        bsel;
        logic [1:0]  shift;
        logic [1:0]  aluop;
        logic        loadc;
        logic        loads;
    } vec_t;

    vec_t        cur;
    vec_t        q[$];
    logic [15:0] m_ir = 16'h0;
    bit          m_valid = 1'b0;

    function automatic vec_t idle_vec(input logic [15:0] ins);
        vec_t v = '0;
        v.w = 1'b1;
        v.sximm8 = {{8{ins[7]}}, ins[7:0]};
        return v;
    endfunction

    // Expands one accepted instruction into the output vector of every busy cycle.
    function automatic void build(input logic [15:0] ins);
        logic [2:0] opc = ins[15:13];
        logic [1:0] op = ins[12:11];
        bit movi = (opc == 3'b110) && (op == 2'b10);
        bit movr = (opc == 3'b110) && (op == 2'b00);
        bit aluc = (opc == 3'b101);
        vec_t base = '0;
        vec_t v;
        base.sximm8 = {{8{ins[7]}}, ins[7:0]};
        v = base;
        v.err = !(movi || movr || aluc);
        q.push_back(v);
        if (movi) begin
            v = base; v.vsel = 1; v.write = 1; v.writenum = ins[10:8];
            q.push_back(v);
        end else if (movr || aluc) begin
            v = base; v.readnum1 = ins[10:8]; v.readnum2 = ins[2:0];
            v.loada = 1; v.loadb = 1;
            q.push_back(v);
            v = base; v.shift = ins[4:3]; v.bsel = 1; v.loadc = 1;
            if (movr) begin
                v.aluop = 2'b00; v.asel = 0; v.loads = 0;
            end else begin
                v.aluop = op;
                v.asel = (op != 2'b11);
                v.loads = FLAGS_ALL ? 1'b1 : (op == 2'b01);
            end
            q.push_back(v);
            if (!(aluc && op == 2'b01)) begin
                v = base; v.write = 1; v.writenum = ins[7:5];
                q.push_back(v);
            end
        end
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_ir = 16'h0;
            cur = idle_vec(16'h0);
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (cur.w) begin
                if (s) begin
                    m_ir = instr;
                    build(instr);
                    cur = q.pop_front();
                end else begin
                    cur = idle_vec(m_ir);
                end
            end else if (q.size() > 0) begin
                cur = q.pop_front();
            end else begin
                cur = idle_vec(m_ir);
            end
        end
    end

    always @(negedge clk) begin
        vec_t act;
        act = '{w, err, sximm8, vsel, writenum, write, readnum1, readnum2,
                loada, loadb, asel, bsel, shift, aluop, loadc, loads};
        if (m_valid) begin
            checks++;
            if (act !== cur) begin
                errors++;
                $display("FAIL outputs t=%0t got=%h expected=%h", $time, act, cur);
            end
        end
    end

    // ---------------- directed helpers ----------------
    int err_cnt, write_cnt, loads_cnt, loadc_cnt, en_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    // Called at a negedge with the controller idle; returns at the negedge where w is back.
    task automatic issue(input logic [15:0] ins, output int lowc);
        s = 1'b1;
        instr = ins;
        @(negedge clk);
        s = 1'b0;
        lowc = 0; err_cnt = 0; write_cnt = 0; loads_cnt = 0; loadc_cnt = 0; en_cnt = 0;
        while (w !== 1'b1 && lowc < 20) begin
            lowc++;
            err_cnt   += int'(err);
            write_cnt += int'(write);
            loads_cnt += int'(loads);
            loadc_cnt += int'(loadc);
            en_cnt    += int'(write | loada | loadb | loadc | loads);
            @(negedge clk);
        end
    endtask

    function automatic logic [15:0] rand_instr();
        logic [31:0] r = $urandom();
        int kind = $urandom_range(5);
        if ($urandom_range(9) < 3) return r[15:0];
        case (kind)
            0:       return {3'b110, 2'b10, r[10:0]};
            1:       return {3'b110, 2'b00, r[10:0]};
            default: return {3'b101, 2'(kind - 2), r[10:0]};
        endcase
    endfunction

    initial begin
        int lowc;
        logic [15:0] r4_before;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_w", {31'b0, w}, 32'd1);
        chk("reset_err", {31'b0, err}, 32'd0);
        chk("reset_sximm8", {16'b0, sximm8}, 32'h0);

        issue(16'hD007, lowc);
        chk("movi_r0_latency", lowc, 2);
        chk("movi_r0_writes", write_cnt, 1);
        chk("r0_value", {16'b0, rf[0]}, 32'h0007);

        issue(16'hD1FE, lowc);
        chk("movi_r1_latency", lowc, 2);
        chk("r1_value", {16'b0, rf[1]}, 32'hFFFE);

        issue(16'hA148, lowc);
        chk("add_latency", lowc, 4);
        chk("add_r2_value", {16'b0, rf[2]}, 32'h000C);

        issue(16'hA901, lowc);
        chk("cmp_latency", lowc, 3);
        chk("cmp_writes", write_cnt, 0);
        chk("cmp_loads", loads_cnt, 1);
        chk("cmp_z", {31'b0, zf}, 32'd1);

        issue(16'hA160, lowc);
        chk("add_r3_value", {16'b0, rf[3]}, 32'h0005);
        chk("z_after_add", {31'b0, zf}, FLAGS_ALL ? 32'd0 : 32'd1);

        issue(16'hE000, lowc);
        chk("illegal_latency", lowc, 1);
        chk("illegal_err_pulses", err_cnt, 1);
        chk("illegal_enables", en_cnt, 0);
        chk("illegal_back_to_wait", {31'b0, w}, 32'd1);

        // s held high: every WAIT visit accepts exactly one instruction
        s = 1'b1;
        instr = 16'hA148;
        loadc_cnt = 0; write_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            loadc_cnt += int'(loadc);
            write_cnt += int'(write);
        end
        s = 1'b0;
        chk("held_s_execs", loadc_cnt, 2);
        chk("held_s_writes", write_cnt, 2);
        chk("held_s_idle", {31'b0, w}, 32'd1);

        // reset during EXEC abandons the write-back
        r4_before = rf[4];
        s = 1'b1;
        instr = 16'hA180;
        @(negedge clk);
        s = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_reset_exec", {31'b0, loadc}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("reset_exec_w", {31'b0, w}, 32'd1);
        chk("reset_exec_loadc", {31'b0, loadc}, 32'd0);
        chk("reset_exec_write", {31'b0, write}, 32'd0);
        repeat (3) @(negedge clk);
        chk("reset_exec_r4", {16'b0, rf[4]}, {16'b0, r4_before});

        // randomized traffic against the model
        repeat (3000) begin
            @(negedge clk);
            reset = ($urandom_range(149) == 0);
            s = ($urandom_range(1) == 1);
            instr = rand_instr();
        end
        reset = 1'b0;
        s = 1'b0;
        repeat (6) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/datapath_ctrl.md
Name: datapath_ctrl

Overview:
- Multi-cycle controller FSM that sequences the 16-bit register/ALU datapath: latches one instruction on `s`, decodes it, and drives every datapath control input for as many cycles as the instruction needs.
- Sits between the instruction source (bench or future fetch unit) and the datapath.
- Raises `w` when idle and ready for the next instruction.

Parameters:
- WIDTH, 16, data width; sets the width of `sximm8`. Must be >= 16.
- ADDR_WIDTH, 3, register-number width. Fixed by the instruction encoding; only 3 is supported.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- s  input  1  start; sampled only in WAIT
- instr  input  16  instruction; captured when `s`=1 in WAIT
- w  output  1  1 only in WAIT (idle/ready)
- err  output  1  one-cycle pulse on an illegal instruction
- sximm8  output  WIDTH  sign-extended imm8 of the latched instruction; drives datapath `in`
- vsel  output  1  1 = regfile write data from `sximm8`, 0 = from datapath `out`
- writenum  output  3  regfile write address
- write  output  1  regfile write enable
- readnum1  output  3  regfile read port 1 (feeds A)
- readnum2  output  3  regfile read port 2 (feeds B)
- loada  output  1  load enable, register A
- loadb  output  1  load enable, register B
- asel  output  1  1 = ALU A input is register A, 0 = zero
- bsel  output  1  1 = ALU B input is shifter output, 0 = zero
- shift  output  2  shifter control
- aluop  output  2  ALU operation
- loadc  output  1  load enable, register C
- loads  output  1  load enable, status (Z)

Behaviour:
- Encoding:
  - opcode = instr[15:13], op = [12:11], Rn = [10:8], Rd = [7:5], sh = [4:3], Rm = [2:0], imm8 = [7:0].
  - Legal instructions:
    - 110/10 MOV Rn,#imm8
    - 110/00 MOV Rd,Rm{,sh}
    - 101/00 ADD
    - 101/01 CMP
    - 101/10 AND
    - 101/11 MVN
  - Every other opcode/op combination is illegal.
- Instruction register: loads `instr` only when state=WAIT and `s`=1. Fields and `sximm8` derive from this register, never directly from `instr`.
- Outputs are Moore-style and default to 0 in every state unless listed below. Reset value: state=WAIT, w=1, err=0, all enables 0, instruction register 0.
- State WAIT:
  - w=1.
  - s=1 goes to DECODE; otherwise stay in WAIT.
- State DECODE:
  - MOV imm goes to WRITE_IMM.
  - Any other legal instruction goes to LOAD_AB.
  - Illegal instruction: err=1 this cycle, then WAIT; no enable is asserted.
- State WRITE_IMM:
  - vsel=1, write=1, writenum=Rn.
  - Next state WAIT.
- State LOAD_AB:
  - readnum1=Rn, readnum2=Rm, loada=1, loadb=1.
  - Next state EXEC.
- State EXEC:
  - shift=sh, bsel=1, loadc=1.
  - MOV reg: aluop=00, asel=0.
  - MVN: aluop=11, asel=0.
  - ADD/CMP/AND: aluop=op, asel=1.
  - loads=1 for CMP only.
  - CMP goes to WAIT; all others go to WB.
- State WB:
  - vsel=0, write=1, writenum=Rd.
  - Next state WAIT.
- Latency, as cycles with w=0 after the accepting edge:
  - illegal: 1
  - MOV imm: 2
  - CMP: 3
  - MOV reg/ADD/AND/MVN: 4
- Boundary conditions:
  - `s` held high outside WAIT is ignored.
  - `s` high on the cycle w returns to 1 starts the next instruction immediately (back-to-back issue).
- Reset asserted in any state:
  - Next cycle is WAIT, w=1, all enables 0.
  - An in-flight instruction is abandoned: no partial write.
  - reset has priority over `s`.

Optional Feature:
- Macro DATAPATH_CTRL_FLAGS_ALL_EN.
- Defined: loads=1 in EXEC for ADD, CMP, AND and MVN, so Z tracks every ALU result.
- Undefined: loads=1 only for CMP.
- MOV reg never sets loads in either configuration.

Decomposition:
- Package dp_ctrl_pkg holds:
  - state enum: WAIT, DECODE, WRITE_IMM, LOAD_AB, EXEC, WB
  - opcode/op localparams: OPC_MOV=3'b110, OPC_ALU=3'b101, OP_MOVI=2'b10, OP_ADD, OP_CMP, OP_AND, OP_MVN
  - instruction field bit positions
- Sub-module instr_dec: combinational field extraction, sign extension, legality flag.

Test Plan:
- Reset, then MOV R0,#7 (instr=16'hD007, s pulse):
  - WRITE_IMM cycle shows vsel=1, write=1, writenum=0, sximm8=16'h0007.
  - w low for exactly 2 cycles.
- MOV R1,#-2 (16'hD1FE): sximm8=16'hFFFE, R1=16'hFFFE.
- With the datapath attached, ADD R2,R1,R0,LSL#1 (16'hA148):
  - LOAD_AB reads R1/R0, EXEC shift=01 aluop=00.
  - WB writes R2=16'h000C; w low 4 cycles.
- CMP R1,R1 (16'hA901):
  - loads=1 in EXEC, Z=1, write never asserted.
  - w low 3 cycles.
  - With the macro, a following ADD producing nonzero sets Z=0; without it, Z stays 1.
- Illegal 16'hE000:
  - err=1 for exactly 1 cycle, no enable asserted, back in WAIT next cycle.
- Robustness:
  - Hold s=1 through an ADD: exactly one instruction executes per WAIT visit.
  - Assert reset during EXEC: next cycle w=1, loadc=0, write=0, destination register unchanged.
